// File: rtl/ddrphy_train_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ddrphy_train_pkg
//  Purpose : Shared types and constants for the DDR3 PHY BCLK read-training
//            controller: FSM state encoding, default BCLK sample patterns,
//            delay-tap width and the window-centre helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package ddrphy_train_pkg;

    localparam int TAP_W = 8;

    localparam logic [7:0] PATTERN_A_DEF = 8'h55;
    localparam logic [7:0] PATTERN_B_DEF = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_CLEAR  = 4'd2,
        ST_SETTLE = 4'd3,
        ST_SAMPLE = 4'd4,
        ST_EVAL   = 4'd5,
        ST_STEP   = 4'd6,
        ST_CENTER = 4'd7,
        ST_DONE   = 4'd8,
        ST_FAIL   = 4'd9
    } train_state_t;

    // Floor midpoint of an inclusive tap window, kept in tap-width arithmetic.
    function automatic logic [TAP_W-1:0] window_center(
        input logic [TAP_W-1:0] first,
        input logic [TAP_W-1:0] last
    );
        logic [TAP_W-1:0] span;
        span = last - first;
        return first + (span >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bclk_sample_chk.sv
`default_nettype none
// ============================================================================
//  Module  : bclk_sample_chk
//  Purpose : Per-tap sample qualifier. Registers RX data and eye flags once,
//            then over SAMPLE_CYCLES enabled cycles tracks whether every word
//            equals PATTERN_A, every word equals PATTERN_B, and both eye flags
//            stayed low.
//  Ports   : clk, rst_n        clock / async active-low reset
//            en                high for the whole sample window
//            rx_data, early, late   raw lane inputs
//            sample_done       high on the last enabled cycle of the window
//            tap_pass          verdict, valid together with sample_done
//  Rev     : 1.0  initial release
// ============================================================================
module bclk_sample_chk
    import ddrphy_train_pkg::*;
#(
    parameter int         SAMPLE_CYCLES = 16,
    parameter logic [7:0] PATTERN_A     = PATTERN_A_DEF,
    parameter logic [7:0] PATTERN_B     = PATTERN_B_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] rx_data,
    input  logic       early,
    input  logic       late,
    output logic       sample_done,
    output logic       tap_pass
);

    localparam int              CNT_W    = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

    logic [7:0]       rx_q;
    logic             early_q;
    logic             late_q;
    logic [CNT_W-1:0] cnt;
    logic             all_a;
    logic             all_b;
    logic             clean;

    logic first_word;
    logic a_now;
    logic b_now;
    logic clean_now;

    // The first word of a window seeds the accumulators instead of ANDing
    // into stale results from the previous tap.
    always_comb begin
        first_word  = (cnt == '0);
        a_now       = (first_word | all_a) & (rx_q == PATTERN_A);
        b_now       = (first_word | all_b) & (rx_q == PATTERN_B);
        clean_now   = (first_word | clean) & ~early_q & ~late_q;
        sample_done = en & (cnt == CNT_LAST);
        tap_pass    = (a_now | b_now) & clean_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q    <= '0;
            early_q <= 1'b0;
            late_q  <= 1'b0;
            cnt     <= '0;
            all_a   <= 1'b0;
            all_b   <= 1'b0;
            clean   <= 1'b0;
        end else begin
            rx_q    <= rx_data;
            early_q <= early;
            late_q  <= late;
            if (en) begin
                cnt   <= sample_done ? '0 : cnt + CNT_W'(1);
                all_a <= a_now;
                all_b <= b_now;
                clean <= clean_now;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddrphy_bclk_train_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : ddrphy_bclk_train_ctrl
//  Purpose : BCLK read-training controller. Sweeps the IOD input delay from
//            its load value, finds the first passing window of at least
//            MIN_WINDOW taps and parks the delay line at the window centre.
//  Ports   : FAB_CLK, ARST_N              clock / async active-low reset
//            TRAIN_START                  start request (ignored while busy)
//            TRAIN_BUSY/DONE/FAIL         status to the training sequencer
//            TAP_COUNT                    current tap relative to load
//            RX_DATA_0, EYE_MONITOR_*_0,
//            DELAY_LINE_OUT_OF_RANGE_0    lane inputs
//            EYE_MONITOR_CLEAR_FLAGS_0,
//            DELAY_LINE_LOAD/MOVE/DIRECTION_0   lane delay controls
//  Rev     : 1.0  initial release
// ============================================================================
module ddrphy_bclk_train_ctrl
    import ddrphy_train_pkg::*;
#(
    parameter int         MAX_TAPS      = 128,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         SAMPLE_CYCLES = 16,
    parameter int         MIN_WINDOW    = 4,
    parameter logic [7:0] PATTERN_A     = PATTERN_A_DEF,
    parameter logic [7:0] PATTERN_B     = PATTERN_B_DEF
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             TRAIN_START,
    output logic             TRAIN_BUSY,
    output logic             TRAIN_DONE,
    output logic             TRAIN_FAIL,
    output logic [TAP_W-1:0] TAP_COUNT,
    input  logic [7:0]       RX_DATA_0,
    input  logic             EYE_MONITOR_EARLY_0,
    input  logic             EYE_MONITOR_LATE_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic             EYE_MONITOR_CLEAR_FLAGS_0,
    output logic             DELAY_LINE_LOAD_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0
);

    localparam int               WAIT_W        = $clog2(SETTLE_CYCLES + 2);
    localparam logic [WAIT_W-1:0] SETTLE_LAST   = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] SETTLE_RELOAD = WAIT_W'(SETTLE_CYCLES);
    localparam logic [TAP_W-1:0]  LAST_TAP      = TAP_W'(MAX_TAPS - 1);

    train_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              after_move;
    logic              tap_pass_q;
    logic              win_open;
    logic [TAP_W-1:0]  win_first;
    logic [TAP_W-1:0]  win_last;
    logic [TAP_W-1:0]  center;

    logic              sample_done;
    logic              tap_pass;

    logic              ev_open;
    logic [TAP_W-1:0]  ev_first;
    logic [TAP_W-1:0]  ev_last;
    logic              ev_center_go;
    logic              ev_meets;
    logic              sweep_end;
    logic              sweep_center;

    function automatic logic span_ok(input logic [TAP_W-1:0] first,
                                     input logic [TAP_W-1:0] last);
        return (last - first) >= TAP_W'(MIN_WINDOW - 1);
    endfunction

    bclk_sample_chk #(
        .SAMPLE_CYCLES (SAMPLE_CYCLES),
        .PATTERN_A     (PATTERN_A),
        .PATTERN_B     (PATTERN_B)
    ) u_sample_chk (
        .clk         (FAB_CLK),
        .rst_n       (ARST_N),
        .en          (state == ST_SAMPLE),
        .rx_data     (RX_DATA_0),
        .early       (EYE_MONITOR_EARLY_0),
        .late        (EYE_MONITOR_LATE_0),
        .sample_done (sample_done),
        .tap_pass    (tap_pass)
    );

    // Window bookkeeping for the current tap verdict. Outside EVAL this just
    // reflects the stored window, so the same terms serve the OOR range hit
    // detected in CLEAR.
    always_comb begin
        ev_open      = win_open;
        ev_first     = win_first;
        ev_last      = win_last;
        ev_center_go = 1'b0;
        if (state == ST_EVAL) begin
            if (tap_pass_q) begin
                if (!win_open) begin
                    ev_open  = 1'b1;
                    ev_first = TAP_COUNT;
                end
                ev_last = TAP_COUNT;
            end else if (win_open) begin
                ev_open      = 1'b0;
                ev_center_go = span_ok(win_first, win_last);
            end
        end
        ev_meets     = ev_open & span_ok(ev_first, ev_last);
        sweep_end    = ((state == ST_CLEAR) & after_move & DELAY_LINE_OUT_OF_RANGE_0) |
                       ((state == ST_EVAL) & (ev_center_go | (TAP_COUNT == LAST_TAP)));
        sweep_center = ev_center_go | ev_meets;
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state                     <= ST_IDLE;
            wait_cnt                  <= '0;
            after_move                <= 1'b0;
            tap_pass_q                <= 1'b0;
            win_open                  <= 1'b0;
            win_first                 <= '0;
            win_last                  <= '0;
            center                    <= '0;
            TRAIN_BUSY                <= 1'b0;
            TRAIN_DONE                <= 1'b0;
            TRAIN_FAIL                <= 1'b0;
            TAP_COUNT                 <= '0;
            EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
            DELAY_LINE_LOAD_0         <= 1'b0;
            DELAY_LINE_MOVE_0         <= 1'b0;
            DELAY_LINE_DIRECTION_0    <= 1'b0;
        end else begin
            EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
            DELAY_LINE_LOAD_0         <= 1'b0;
            DELAY_LINE_MOVE_0         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (TRAIN_START) begin
                        state                  <= ST_LOAD;
                        TRAIN_BUSY             <= 1'b1;
                        TRAIN_DONE             <= 1'b0;
                        TRAIN_FAIL             <= 1'b0;
                        TAP_COUNT              <= '0;
                        win_open               <= 1'b0;
                        win_first              <= '0;
                        win_last               <= '0;
                        DELAY_LINE_DIRECTION_0 <= 1'b1;
                        DELAY_LINE_LOAD_0      <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    state                     <= ST_CLEAR;
                    after_move                <= 1'b0;
                    EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
                end

                // TAP_COUNT only advances once the line confirms the move
                // landed in range, so an OOR hit leaves it on the last tap.
                ST_CLEAR, ST_EVAL: begin
                    if (state == ST_EVAL) begin
                        win_open  <= ev_open;
                        win_first <= ev_first;
                        win_last  <= ev_last;
                    end
                    if (sweep_end) begin
                        if (sweep_center) begin
                            state                  <= ST_CENTER;
                            center                 <= window_center(ev_first, ev_last);
                            wait_cnt               <= '0;
                            DELAY_LINE_DIRECTION_0 <= 1'b0;
                        end else begin
                            state      <= ST_FAIL;
                            TRAIN_FAIL <= 1'b1;
                            TRAIN_BUSY <= 1'b0;
                        end
                    end else if (state == ST_CLEAR) begin
                        if (after_move) begin
                            TAP_COUNT <= TAP_COUNT + TAP_W'(1);
                        end
                        wait_cnt <= SETTLE_LAST;
                        state    <= ST_SETTLE;
                    end else begin
                        state             <= ST_STEP;
                        DELAY_LINE_MOVE_0 <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (wait_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    if (sample_done) begin
                        tap_pass_q <= tap_pass;
                        state      <= ST_EVAL;
                    end
                end

                ST_STEP: begin
                    state                     <= ST_CLEAR;
                    after_move                <= 1'b1;
                    EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
                end

                // One decrement every SETTLE_CYCLES+1 cycles; the final move
                // also gets its settle time before DONE is declared.
                ST_CENTER: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else if (TAP_COUNT == center) begin
                        state      <= ST_DONE;
                        TRAIN_DONE <= 1'b1;
                        TRAIN_BUSY <= 1'b0;
                    end else begin
                        DELAY_LINE_MOVE_0 <= 1'b1;
                        TAP_COUNT         <= TAP_COUNT - TAP_W'(1);
                        wait_cnt          <= SETTLE_RELOAD;
                    end
                end

                ST_DONE, ST_FAIL: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddrphy_bclk_train_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ddrphy_bclk_train_ctrl
//  Purpose : Bench for ddrphy_bclk_train_ctrl with a behavioural IOD lane
//            model (delay position, per-tap data/eye/OOR behaviour) and a
//            scoreboard of expected training outcomes.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ddrphy_bclk_train_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail;
    logic [7:0] tap;
    logic [7:0] rx = 8'h00;
    logic       early = 1'b0;
    logic       late = 1'b0;
    logic       oor = 1'b0;
    logic       clr, load, move, dir;

    always #5 clk = ~clk;

    ddrphy_bclk_train_ctrl dut (
        .FAB_CLK                   (clk),
        .ARST_N                    (rst_n),
        .TRAIN_START               (start),
        .TRAIN_BUSY                (busy),
        .TRAIN_DONE                (done),
        .TRAIN_FAIL                (fail),
        .TAP_COUNT                 (tap),
        .RX_DATA_0                 (rx),
        .EYE_MONITOR_EARLY_0       (early),
        .EYE_MONITOR_LATE_0        (late),
        .DELAY_LINE_OUT_OF_RANGE_0 (oor),
        .EYE_MONITOR_CLEAR_FLAGS_0 (clr),
        .DELAY_LINE_LOAD_0         (load),
        .DELAY_LINE_MOVE_0         (move),
        .DELAY_LINE_DIRECTION_0    (dir)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- IOD lane model ----------------
    int         p1_lo = 1000, p1_hi = -1, p2_lo = 1000, p2_hi = -1;
    logic [7:0] pat = 8'h55;
    int         mixed_tap = -1, late_tap = -1, oor_tap = 1000;
    int         model_tap = 0;
    int         since_move = 0;
    bit         mix_t = 1'b0;

    function automatic bit tap_passes(input int t);
        return (t >= p1_lo && t <= p1_hi) || (t >= p2_lo && t <= p2_hi);
    endfunction

    always @(negedge clk) begin
        if (load) begin
            model_tap  = 0;
            since_move = 0;
        end else if (move) begin
            model_tap  = dir ? model_tap + 1 : model_tap - 1;
            since_move = 0;
        end else begin
            since_move++;
        end
        mix_t = ~mix_t;
        if (tap_passes(model_tap))       rx = pat;
        else if (model_tap == mixed_tap) rx = mix_t ? 8'h55 : 8'hAA;
        else                             rx = 8'h00;
        late = (model_tap == late_tap) && (since_move == 12);
        oor  = (model_tap >= oor_tap);
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        bit d;
        bit f;
        int tap;
        int dec;
        int line;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_loads = 0, n_dec = 0;
    bit prev_fin = 1'b0, prev_move = 1'b0, prev_dir = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_loads = 0; n_dec = 0;
            prev_fin = 1'b0; prev_move = 1'b0; prev_dir = 1'b0;
        end else begin
            if (load) n_loads++;
            if (move && !dir) n_dec++;
            if (move) begin
                chk("dir_setup", int'(dir), int'(prev_dir));
                chk("move_width", int'(prev_move), 0);
            end
            if (prev_move) chk("dir_hold", int'(dir), int'(prev_dir));
            if ((done | fail) && !prev_fin) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done", int'(done), int'(e.d));
                    chk("fail", int'(fail), int'(e.f));
                    chk("busy_at_end", int'(busy), 0);
                    chk("final_tap", int'(tap), e.tap);
                    chk("center_moves", n_dec, e.dec);
                    chk("load_pulses", n_loads, 1);
                    chk("line_position", model_tap, e.line);
                end
                n_loads = 0;
                n_dec   = 0;
            end
            prev_fin  = done | fail;
            prev_move = move;
            prev_dir  = dir;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cfg(input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                       input logic [7:0] p, input int mx, input int lt, input int ot);
        p1_lo = a_lo; p1_hi = a_hi; p2_lo = b_lo; p2_hi = b_hi;
        pat = p; mixed_tap = mx; late_tap = lt; oor_tap = ot;
    endtask

    task automatic push(input bit d, input bit f, input int t, input int dc, input int ln);
        exp_t x;
        x.d = d; x.f = f; x.tap = t; x.dec = dc; x.line = ln;
        sb.push_back(x);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_load", int'(load), 1);
        chk("start_busy", int'(busy), 1);
        chk("start_tap", int'(tap), 0);
        chk("start_flags", int'({done, fail}), 0);
    endtask

    task automatic wait_finish();
        int i;
        for (i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            if (done | fail) break;
        end
        if (i == 6000) chk("finish_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, int'({busy, done, fail, tap, clr, load, move, dir}), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle_after_reset");

        // Window 20..40 -> centre 30 after 11 decrements; START in DONE cycle dropped.
        cfg(20, 40, 1000, -1, 8'h55, -1, -1, 1000);
        push(1, 0, 30, 11, 30);
        start_run();
        wait_finish();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_done_load", int'(load), 0);
        chk("start_in_done_flag", int'({busy, done}), 1);
        repeat (3) @(posedge clk); #1;

        // Short window 10..12 discarded, mixed A/B words at 49 fail, centre 60.
        cfg(10, 12, 50, 70, 8'hAA, 49, -1, 1000);
        push(1, 0, 60, 11, 60);
        start_run();
        wait_finish();
        repeat (3) @(posedge clk); #1;

        // No pass; OOR after the move to 127 -> FAIL, count stays at 126.
        cfg(1000, -1, 1000, -1, 8'h55, -1, -1, 127);
        push(0, 1, 126, 0, 127);
        start_run();
        wait_finish();
        repeat (3) @(posedge clk); #1;

        // Window 100..127 closes at the last tap -> centre 113, 14 decrements.
        cfg(100, 127, 1000, -1, 8'h55, -1, -1, 1000);
        push(1, 0, 113, 14, 113);
        start_run();
        wait_finish();
        repeat (3) @(posedge clk); #1;

        // LATE pulse during tap 30 sampling -> window 31..40, centre 35.
        cfg(30, 40, 1000, -1, 8'h55, -1, 30, 1000);
        push(1, 0, 35, 6, 35);
        start_run();
        wait_finish();
        repeat (3) @(posedge clk); #1;

        // Async reset in SAMPLE at tap 15, then restart with an ignored START.
        cfg(20, 40, 1000, -1, 8'h55, -1, -1, 1000);
        start_run();
        begin
            int j;
            for (j = 0; j < 2000; j++) begin
                if (tap == 8'd15) break;
                @(posedge clk); #1;
            end
            if (j == 2000) chk("reach_tap15_timeout", 0, 1);
        end
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        @(posedge clk); #1;
        check_all_zero("reset_held_outputs");
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        push(1, 0, 30, 11, 30);
        start_run();
        repeat (50) @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_load", int'(load), 0);
        chk("busy_start_busy", int'(busy), 1);
        wait_finish();
        repeat (4) @(posedge clk); #1;

        chk("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
